// File: rtl/dt_res_packer_if.sv
// Result-RAM read port and packed-RAM write port of the distance-map packer.
// master = packer side, slave = RAM side.
interface dt_res_packer_if #(
  parameter int PIX_AW  = 14,
  parameter int WORD_AW = 10,
  parameter int DW      = 8
);
  logic               res_rd;
  logic [PIX_AW-1:0]  res_addr;
  logic [DW-1:0]      res_di;
  logic               pk_wr;
  logic [WORD_AW-1:0] pk_addr;
  logic [15:0]        pk_do;

  modport master (output res_rd, res_addr, pk_wr, pk_addr, pk_do, input res_di);
  modport slave  (input res_rd, res_addr, pk_wr, pk_addr, pk_do, output res_di);
endinterface

// File: rtl/dt_res_packer.sv
// Reads the 8-bit distance map, thresholds each pixel (d >= thr) and packs 16
// pixels per word, MSB first. Optional macro PK_POPCNT_EN adds obj_cnt.
module dt_res_packer #(
  parameter int PIX_AW  = 14,
  parameter int WORD_AW = 10,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] thr,
  dt_res_packer_if.master bus,
  output logic          done
`ifdef PK_POPCNT_EN
  ,
  output logic [PIX_AW:0] obj_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             st, st_nxt;
  logic [PIX_AW:0]    pix_cnt;   // MSB set once every address has been issued
  logic               cap_vld;   // res_di holds a requested pixel this cycle
  logic [14:0]        shreg;
  logic [3:0]         bit_cnt;
  logic [WORD_AW-1:0] word_cnt;
  logic               bit_in;
  logic [15:0]        word_nxt;
  logic               go;

  assign bit_in   = (bus.res_di >= thr);
  assign word_nxt = {shreg, bit_in};
  assign go       = ((st == S_IDLE) || (st == S_DONE)) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE, S_DONE: if (start) st_nxt = S_RUN;
      S_RUN:          if (pix_cnt[PIX_AW]) st_nxt = S_DRAIN;
      S_DRAIN:        if (bus.pk_wr && (&bus.pk_addr)) st_nxt = S_DONE;
      default:        st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.res_rd   <= 1'b0;
      bus.res_addr <= '0;
      bus.pk_wr    <= 1'b0;
      bus.pk_addr  <= '0;
      bus.pk_do    <= '0;
      done         <= 1'b0;
      pix_cnt      <= '0;
      cap_vld      <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
`ifdef PK_POPCNT_EN
      obj_cnt      <= '0;
`endif
    end else begin
      bus.pk_wr <= 1'b0;
      cap_vld   <= bus.res_rd;

      if (go) begin
        bus.res_addr <= '0;
        done         <= 1'b0;
        pix_cnt      <= '0;
        shreg        <= '0;
        bit_cnt      <= '0;
        word_cnt     <= '0;
`ifdef PK_POPCNT_EN
        obj_cnt      <= '0;
`endif
      end

      // Address issue: one pixel per cycle, res_addr parks on the last pixel
      if (st == S_RUN && !pix_cnt[PIX_AW]) begin
        bus.res_rd   <= 1'b1;
        bus.res_addr <= pix_cnt[PIX_AW-1:0];
        pix_cnt      <= pix_cnt + (PIX_AW+1)'(1);
      end else begin
        bus.res_rd   <= 1'b0;
      end

      if (st == S_DRAIN && st_nxt == S_DONE) done <= 1'b1;

      // Capture: the 16th bit of a word goes straight into pk_do
      if (cap_vld) begin
        shreg   <= word_nxt[14:0];
        bit_cnt <= bit_cnt + 4'd1;
`ifdef PK_POPCNT_EN
        obj_cnt <= obj_cnt + (PIX_AW+1)'(bit_in);
`endif
        if (&bit_cnt) begin
          bus.pk_wr   <= 1'b1;
          bus.pk_addr <= word_cnt;
          bus.pk_do   <= word_nxt;
          word_cnt    <= word_cnt + WORD_AW'(1);
        end
      end
    end
  end

endmodule
